// File: rtl/bit_serial_pkg.sv
// ============================================================================
// Module  : bit_serial_pkg
// Brief   : Shared types and helpers for the bit-serial subtractor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bit_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit-counter width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage : bit_serial_pkg

`default_nettype wire

// File: rtl/full_subtractor_1bit.sv
// ============================================================================
// Module  : full_subtractor_1bit
// Brief   : Combinational one-bit full subtractor cell (a - b - b_in).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module full_subtractor_1bit (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic diff,
    output logic b_out
);

    assign diff  = a ^ b ^ b_in;
    assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule : full_subtractor_1bit

`default_nettype wire

// File: rtl/bit_serial_subtractor.sv
// ============================================================================
// Module  : bit_serial_subtractor
// Brief   : LSB-first serial a - b using one full-subtractor cell over WIDTH
//           cycles, with valid/ready handshakes on both sides.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_serial_subtractor
    import bit_serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             busy
);

    localparam int               CNT_W  = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [WIDTH-1:0]   a_sh_q,   a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,   b_sh_d;
    logic [WIDTH-1:0]   diff_q,   diff_d;
    logic               borrow_q, borrow_d;
    logic               a_msb_q,  a_msb_d;
    logic               b_msb_q,  b_msb_d;

    logic               w_cell_diff;
    logic               w_cell_bout;

    full_subtractor_1bit u_cell (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .b_in  (borrow_q),
        .diff  (w_cell_diff),
        .b_out (w_cell_bout)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    a_msb_d  = a[WIDTH-1];
                    b_msb_d  = b[WIDTH-1];
                    diff_d   = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
                diff_d   = {w_cell_diff, diff_q[WIDTH-1:1]};
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                borrow_d = w_cell_bout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == C_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q == RUN);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    // Signed overflow: operand signs differ and the result sign departs from the minuend.
    assign overflow   = (a_msb_q != b_msb_q) && (diff_q[WIDTH-1] != a_msb_q);

endmodule : bit_serial_subtractor

`default_nettype wire

// File: tb/tb_bit_serial_subtractor.sv
// ============================================================================
// Module  : tb_bit_serial_subtractor
// Brief   : Directed and random scoreboard bench for bit_serial_subtractor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bit_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;
    logic             busy;

    bit_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             bo;
        logic             ov;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   acc_cyc = 0;

    function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb);
        exp_t e;
        int   sa, sbv, sd;
        e.d  = ma - mb;
        e.bo = (ma < mb);
        sa   = int'($signed(ma));
        sbv  = int'($signed(mb));
        sd   = sa - sbv;
        e.ov = (sd > 127) || (sd < -128);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        chk("accept_ready", {31'd0, in_ready}, 32'd1);
        a        = ta;
        b        = tb_v;
        in_valid = 1'b1;
        sb_q.push_back(model(ta, tb_v));
        tick();
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("out_valid_seen", {31'd0, out_valid}, 32'd1);
    endtask

    // Compare the current outputs to the oldest expected result and retire it.
    task automatic cmp_front(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, {31'd0, (sb_q.size() != 0)}, 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, "_diff"},   {24'd0, diff},       {24'd0, e.d});
            chk({tag, "_borrow"}, {31'd0, borrow_out}, {31'd0, e.bo});
            chk({tag, "_ovf"},    {31'd0, overflow},   {31'd0, e.ov});
        end
    endtask

    task automatic take(input string tag);
        out_ready = 1'b1;
        cmp_front(tag);
        tick();
        chk({tag, "_idle_after"}, {31'd0, in_ready}, 32'd1);
    endtask

    logic [WIDTH-1:0] vec_a [3];
    logic [WIDTH-1:0] vec_b [3];

    initial begin
        int lat;
        int prev;
        int done;
        int g;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        tick();
        tick();
        chk("rst_in_ready",  {31'd0, in_ready},   32'd1);
        chk("rst_out_valid", {31'd0, out_valid},  32'd0);
        chk("rst_busy",      {31'd0, busy},       32'd0);
        chk("rst_diff",      {24'd0, diff},       32'd0);
        chk("rst_borrow",    {31'd0, borrow_out}, 32'd0);
        chk("rst_ovf",       {31'd0, overflow},   32'd0);
        rst_n = 1'b1;
        tick();

        // Basic operation and latency
        accept(8'h5A, 8'h3C);
        chk("run_busy",     {31'd0, busy},     32'd1);
        chk("run_in_ready", {31'd0, in_ready}, 32'd0);
        wait_valid(lat);
        chk("latency", lat, WIDTH);
        take("basic");

        // Boundary vectors
        vec_a[0] = 8'h00; vec_b[0] = 8'h01;
        vec_a[1] = 8'h80; vec_b[1] = 8'h01;
        vec_a[2] = 8'h7F; vec_b[2] = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            accept(vec_a[i], vec_b[i]);
            wait_valid(lat);
            take("edge");
        end

        // Backpressure: result held while out_ready low
        out_ready = 1'b0;
        accept(8'h33, 8'h33);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_diff",  {24'd0, diff},      32'd0);
            tick();
        end
        take("hold");

        // Operand changes and in_valid during RUN are ignored
        accept(8'hA5, 8'h0F);
        in_valid = 1'b1;
        lat = 0;
        while (!out_valid && lat < 40) begin
            chk("ignore_in_ready", {31'd0, in_ready}, 32'd0);
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            tick();
            lat++;
        end
        in_valid = 1'b0;
        chk("ignore_valid_seen", {31'd0, out_valid}, 32'd1);
        take("ignore");

        // Asynchronous reset in the middle of RUN
        accept(8'h77, 8'h11);
        tick();
        tick();
        tick();
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",      {31'd0, busy},       32'd0);
        chk("mid_rst_out_valid", {31'd0, out_valid},  32'd0);
        chk("mid_rst_in_ready",  {31'd0, in_ready},   32'd1);
        chk("mid_rst_diff",      {24'd0, diff},       32'd0);
        chk("mid_rst_borrow",    {31'd0, borrow_out}, 32'd0);
        sb_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        accept(8'h10, 8'h01);
        wait_valid(lat);
        take("post_rst");

        // Random back-to-back traffic with random consumer stalls
        prev = 0;
        for (int i = 0; i < 100; i++) begin
            accept(WIDTH'($urandom), WIDTH'($urandom));
            if (i > 0) begin
                chk("spacing", {31'd0, ((acc_cyc - prev) >= WIDTH + 2)}, 32'd1);
            end
            prev = acc_cyc;
            done = 0;
            g    = 0;
            while (done == 0 && g < 80) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    cmp_front("rand");
                    done = 1;
                end
                tick();
                g++;
            end
            chk("rand_handshake", done, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_bit_serial_subtractor

`default_nettype wire
